// File: rtl/axi_store_wr_pkg.sv
// Shared constants, FSM state encoding and response decoding for the LSU store write master.
package axi_store_wr_pkg;

  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEND   = 2'b01,
    ST_WAIT_B = 2'b10
  } axi_store_wr_state_e;

  // SLVERR and DECERR are errors to the memory stage; both OKAY flavours retire cleanly.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    err = 1'b0;
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:  err = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
      default:                          err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi_store_wr_if.sv
// AXI4 write-only bus (AW, W, B) between the store write master and the memory fabric.
interface axi_store_wr_if
  import axi_store_wr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) ();

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );

endinterface

// File: rtl/axi_store_wr_mask2strb.sv
// Collapses a lane-shifted bit mask into AXI byte strobes; each mask byte is all-1 or all-0.
module axi_store_wr_mask2strb
  import axi_store_wr_pkg::*;
(
  input  logic [DATA_W-1:0] mask,
  output logic [STRB_W-1:0] strb
);

  // Only the low bit of each byte is sampled; the rest are redundant copies.
  for (genvar i = 0; i < STRB_W; i++) begin : g_lane
    assign strb[i] = mask[8*i];
  end

  logic unused_mask_bits;
  assign unused_mask_bits = ^mask;

endmodule

// File: rtl/axi_store_wr.sv
// LSU store write master: one single-beat AXI4 write per accepted store, one store in flight.
module axi_store_wr
  import axi_store_wr_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [63:0]        req_addr,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [DATA_W-1:0]  req_mask,
  output logic               done,
  output logic               done_err,
  output logic               busy,
  axi_store_wr_if.master     m_axi
);

  axi_store_wr_state_e state_q, state_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [ADDR_W-1:3]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [STRB_W-1:0]   req_strb;

  axi_store_wr_mask2strb u_mask2strb (
    .mask (req_mask),
    .strb (req_strb)
  );

  // Address bits above the bus width and below the 8-byte beat are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[63:ADDR_W], req_addr[2:0]};

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr[ADDR_W-1:3];
          data_d    = req_data;
          strb_d    = req_strb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // Handshakes landing this cycle count, so both channels may close together.
        if (m_axi.awready) aw_pend_d = 1'b0;
        if (m_axi.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (m_axi.bvalid) begin
          done_d  = 1'b1;
          err_d   = resp_is_err(m_axi.bresp);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign done_err  = err_q;

  // Valids come straight from the pending flags, so they cannot glitch or drop early.
  assign m_axi.awvalid = aw_pend_q;
  assign m_axi.awaddr  = {addr_q, 3'b000};
  assign m_axi.awid    = AXI_ID;
  assign m_axi.awlen   = AXI_LEN_SINGLE;
  assign m_axi.awsize  = AXI_SIZE_8B;
  assign m_axi.awburst = AXI_BURST_INCR;

  assign m_axi.wvalid  = w_pend_q;
  assign m_axi.wdata   = data_q;
  assign m_axi.wstrb   = strb_q;
  assign m_axi.wlast   = 1'b1;

  assign m_axi.bready  = (state_q == ST_WAIT_B);

endmodule

// File: tb/tb_axi_store_wr.sv
// Bench for axi_store_wr: directed stores plus random stores with a randomly stalling AXI slave.
module tb_axi_store_wr;

  localparam int              ADDR_W = 32;
  localparam int              ID_W   = 4;
  localparam logic [ID_W-1:0] AXI_ID = 4'h5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [63:0] req_mask;
  logic        done;
  logic        done_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  axi_store_wr_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  axi_store_wr #(.ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .done      (done),
    .done_err  (done_err),
    .busy      (busy),
    .m_axi     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: beat-aligned address, one strobe per non-empty byte, error on resp >= 2.
  function automatic logic [31:0] exp_awaddr(input logic [63:0] a);
    return 32'(a) & ~32'd7;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [63:0] m);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) if (m[8*i +: 8] != 8'h00) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] mask_from_bytes(input logic [7:0] en);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) if (en[i]) m[8*i +: 8] = 8'hff;
    return m;
  endfunction

  // Starts in a cycle where the DUT must be idle; ends in the cycle done is expected high.
  task automatic do_store(input logic [63:0] addr, input logic [63:0] data, input logic [63:0] mask,
                          input int aw_d, input int w_d, input int b_d, input logic [1:0] resp);
    logic [31:0] e_addr;
    logic [7:0]  e_strb;
    bit          aw_done, w_done, aw_go, w_go;
    int          k;
    e_addr = exp_awaddr(addr);
    e_strb = exp_strb(mask);
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_mask  = mask;
    step();
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_data  = {$urandom, $urandom};
    req_mask  = {$urandom, $urandom};
    chk1("req_ready_send", req_ready, 1'b0);
    chk1("busy_send", busy, 1'b1);
    chk1("done_after_accept", done, 1'b0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    k       = 0;
    while (!(aw_done && w_done) && k < 64) begin
      chk1("awvalid", bus.awvalid, !aw_done);
      chk1("wvalid", bus.wvalid, !w_done);
      chk1("bready_send", bus.bready, 1'b0);
      chk1("done_send", done, 1'b0);
      if (!aw_done) begin
        chk("awaddr", 64'(bus.awaddr), 64'(e_addr));
        chk("awid", 64'(bus.awid), 64'(AXI_ID));
        chk("aw_len_size_burst", 64'({bus.awlen, bus.awsize, bus.awburst}), 64'({8'd0, 3'b011, 2'b01}));
      end
      if (!w_done) begin
        chk("wdata", bus.wdata, data);
        chk("wstrb", 64'(bus.wstrb), 64'(e_strb));
        chk1("wlast", bus.wlast, 1'b1);
      end
      aw_go       = !aw_done && (k >= aw_d);
      w_go        = !w_done && (k >= w_d);
      bus.awready = aw_go || (aw_done && $urandom_range(0, 1) == 1);
      bus.wready  = w_go || (w_done && $urandom_range(0, 1) == 1);
      bus.bvalid  = ($urandom_range(0, 1) == 1);
      bus.bresp   = 2'($urandom);
      step();
      if (aw_go) aw_done = 1'b1;
      if (w_go)  w_done  = 1'b1;
      k++;
    end
    chk1("send_complete", aw_done && w_done, 1'b1);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    for (int j = 0; j < b_d; j++) begin
      chk1("bready_wait", bus.bready, 1'b1);
      chk1("awvalid_wait", bus.awvalid, 1'b0);
      chk1("busy_wait", busy, 1'b1);
      chk1("done_wait", done, 1'b0);
      step();
    end
    chk1("bready_wait", bus.bready, 1'b1);
    bus.bvalid = 1'b1;
    bus.bresp  = resp;
    step();
    bus.bvalid = 1'b0;
    bus.bresp  = 2'($urandom);
    chk1("done", done, 1'b1);
    chk1("done_err", done_err, resp >= 2'd2);
    chk1("busy_done", busy, 1'b0);
    chk1("req_ready_done", req_ready, 1'b1);
    chk1("bready_done", bus.bready, 1'b0);
    chk("wdata_hold", bus.wdata, data);
    chk("wstrb_hold", 64'(bus.wstrb), 64'(e_strb));
    chk("awaddr_hold", 64'(bus.awaddr), 64'(e_addr));
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = 64'd0;
    req_data    = 64'd0;
    req_mask    = 64'd0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    repeat (3) step();
    chk1("rst_awvalid", bus.awvalid, 1'b0);
    chk1("rst_wvalid", bus.wvalid, 1'b0);
    chk1("rst_bready", bus.bready, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_done_err", done_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk("rst_awaddr", 64'(bus.awaddr), 64'd0);
    chk("rst_wdata", bus.wdata, 64'd0);
    chk("rst_wstrb", 64'(bus.wstrb), 64'd0);
    rst = 1'b0;
    step();

    // Byte store at an unaligned address, slave always ready.
    do_store(64'h0000_0000_8000_0003, 64'h0000_0000_a500_0000, 64'hff << 24, 0, 0, 2, 2'b00);
    // AW stalled five cycles while W goes through at once.
    do_store(64'h0000_0001_1234_5678, 64'h1122_3344_5566_7788, 64'h0000_0000_ffff_0000, 5, 0, 0, 2'b00);
    // Full doubleword with SLVERR.
    do_store(64'h0000_0000_4000_0010, 64'hdead_beef_cafe_f00d, 64'hffff_ffff_ffff_ffff, 0, 0, 1, 2'b10);
    // W stalled behind AW, DECERR.
    do_store(64'h0000_0000_0000_0ff8, 64'h0123_4567_89ab_cdef, 64'hffff_ffff_0000_0000, 1, 4, 0, 2'b11);
    // Empty mask still produces a transaction; EXOKAY is not an error.
    do_store(64'hffff_ffff_ffff_fffc, 64'h5a5a_5a5a_5a5a_5a5a, 64'd0, 2, 2, 3, 2'b01);
    step();
    chk1("done_one_cycle", done, 1'b0);
    chk1("idle_after_done", busy, 1'b0);

    // Reset while AW and W are both stalled in SEND.
    req_valid = 1'b1;
    req_addr  = 64'h0000_0000_9000_0000;
    req_data  = 64'h0f0f_0f0f_0f0f_0f0f;
    req_mask  = 64'hffff_ffff_ffff_ffff;
    step();
    req_valid = 1'b0;
    chk1("abort_awvalid_pre", bus.awvalid, 1'b1);
    step();
    chk1("abort_awvalid_hold", bus.awvalid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("abort_awvalid", bus.awvalid, 1'b0);
    chk1("abort_wvalid", bus.wvalid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_req_ready", req_ready, 1'b1);
    for (int j = 0; j < 3; j++) begin
      bus.bvalid = 1'b1;
      step();
      chk1("abort_no_done", done, 1'b0);
      chk1("abort_idle", busy, 1'b0);
    end
    bus.bvalid = 1'b0;

    // Random stores, some back-to-back with the previous done pulse, some after idle gaps.
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk1("gap_done", done, 1'b0);
        chk1("gap_busy", busy, 1'b0);
      end
      do_store({$urandom, $urandom}, {$urandom, $urandom}, mask_from_bytes(8'($urandom)),
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 2'($urandom));
    end
    step();
    chk1("final_done", done, 1'b0);
    chk1("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
